mdu_seq: RTL and testbench
==========================

Name: mdu_seq

Overview:
- Iterative multiply/divide sequencer beside the 32-bit ALU in the EX stage.
- Owns the HI/LO registers and runs MULT/MULTU/DIV/DIVU as radix-2 shift-add or restoring-subtract over WIDTH cycles.
- Raises busy so the hazard unit stalls HI/LO consumers, and supports pipeline flush.

Parameters:
- WIDTH, 32: operand width. Counter width is clog2(WIDTH)+1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  issue request from EX; sampled on clk rising edge.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved (no effect).
- a  in  WIDTH  rs operand.
- b  in  WIDTH  rt operand.
- flush  in  1  pipeline flush; aborts any operation in progress.
- busy  out  1  operation in flight; hazard unit stalls mfhi/mflo and new mdu ops.
- done  out  1  one-cycle pulse; hi/lo hold the new result in this cycle.
- div_by_zero  out  1  valid only with done; set for DIV/DIVU with b==0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: state IDLE; hi=lo=0; busy=done=div_by_zero=0; counter=0.
- Registered outputs only; no combinational path from inputs to outputs.
- States: IDLE, RUN, FIX, DONE.
- Acceptance: start is accepted only in IDLE or DONE, and only with flush=0. Call the acceptance edge cycle 0.
- Start while busy=1 is ignored (no queueing). Reserved op codes are ignored.
- MTHI/MTLO: on the acceptance edge, hi (or lo) <= a. busy and done are not asserted; state stays IDLE.
- MULT/DIV entry:
  - Latch |a| and |b| (signed ops) or raw a and b (unsigned ops).
  - Latch the result sign flags.
  - Set counter=WIDTH and enter RUN.
  - busy=1 from cycle 1.
- RUN:
  - One radix-2 step per cycle; counter decrements each cycle.
  - Leave RUN when counter reaches 0, after WIDTH cycles (cycles 1..32).
  - Working registers are separate from hi/lo.
- FIX (cycle 33):
  - Signed MULT: negate the 64-bit product if sign(a)^sign(b).
  - Signed DIV: negate the quotient if sign(a)^sign(b); negate the remainder if sign(a).
  - Write hi<=product[63:32] or remainder; lo<=product[31:0] or quotient.
  - Next state DONE.
- DONE (cycle 34): done=1, busy=0. Next state IDLE, or RUN if a new start is accepted.
- Divide by zero:
  - Detected in IDLE when op is DIV/DIVU and b==0.
  - Skip RUN and FIX; go to DONE in cycle 1 with div_by_zero=1.
  - hi/lo unchanged.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (natural wrap). No exception.
- Flush:
  - flush=1 in RUN or FIX: next state IDLE, busy=0 next cycle, no done, hi/lo keep pre-op values.
  - flush in DONE: done still pulses (hi/lo were already committed).
  - flush has priority over start in the same cycle.
- rst mid-operation: same effect as the reset values above, including hi=lo=0.

Decomposition:
- Shared package mdu_pkg:
  - op code localparams (OP_MULT..OP_MTLO).
  - state encoding (IDLE/RUN/FIX/DONE).
  - WIDTH default.
  - The ALU op decoder also uses these op codes.
- Sub-module mdu_step (combinational, single radix-2 iteration):
  - mul: conditional add, shift.
  - div: trial subtract, restore, shift in quotient bit.
  - mdu_seq holds the FSM, counter, sign flags and HI/LO.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy cycles 1-33; done at cycle 34; hi=0xFFFFFFFE, lo=0x00000001, div_by_zero=0.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=5 b=0, with hi=0x11, lo=0x22 preloaded via MTHI/MTLO -> done and div_by_zero at cycle 1, never busy; hi=0x11, lo=0x22.
- DIVU a=100 b=7; flush at cycle 10 -> busy=0 at cycle 11; no done for 40 cycles; hi/lo unchanged.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0. A second start at cycle 5 with op=MTHI a=0xDEAD is ignored; hi stays 0.
- rst asserted at cycle 20 of a MULTU -> next cycle busy=0, done=0, hi=lo=0, state IDLE; a fresh start is accepted immediately.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared op codes, FSM encoding and default width for the multiply/divide unit.
// The ALU op decoder imports the same op codes.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic op_is_arith(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// Issue/result bundle between the EX stage and the multiply/divide sequencer.
interface mdu_seq_if #(parameter int WIDTH = 32);
  // Handshake: start is taken on a rising edge only when the unit is idle or
  // in its done cycle and flush is low; there is no ready, so a start while
  // busy is dropped. done pulses for one cycle with hi/lo already updated.
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, flush,
                  input  busy, done, div_by_zero, hi, lo);
  modport slave  (input  start, op, a, b, flush,
                  output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring subtract for divide.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] w_hi,
  input  logic [WIDTH-1:0] w_lo,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] n_hi,
  output logic [WIDTH-1:0] n_lo
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    sum     = {1'b0, w_hi} + (w_lo[0] ? {1'b0, b} : '0);
    shifted = {w_hi, w_lo[WIDTH-1]};
    trial   = shifted - {1'b0, b};
    n_hi    = '0;
    n_lo    = '0;
    if (is_div) begin
      // A borrow out of the trial subtract means the divisor did not fit.
      if (!trial[WIDTH]) begin
        n_hi = trial[WIDTH-1:0];
        n_lo = {w_lo[WIDTH-2:0], 1'b1};
      end else begin
        n_hi = shifted[WIDTH-1:0];
        n_lo = {w_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      n_hi = sum[WIDTH:1];
      n_lo = {sum[0], w_lo[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/mdu_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; WIDTH steps on
// magnitudes, then a sign fix-up cycle before committing the result.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  mdu_seq_if.slave    bus,
  output state_t      state
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   w_hi, w_lo, w_b;
  logic [WIDTH-1:0]   n_hi, n_lo;
  logic               is_div, neg_q, neg_r;

  logic               accept, op_signed, op_div, neg_a, neg_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  always_comb begin
    accept    = bus.start && !bus.flush && (state == S_IDLE || state == S_DONE);
    op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    op_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    neg_a     = op_signed && bus.a[WIDTH-1];
    neg_b     = op_signed && bus.b[WIDTH-1];
    abs_a     = neg_a ? -bus.a : bus.a;
    abs_b     = neg_b ? -bus.b : bus.b;
    prod      = {w_hi, w_lo};
    prod_fix  = neg_q ? -prod : prod;
    q_fix     = neg_q ? -w_lo : w_lo;
    r_fix     = neg_r ? -w_hi : w_hi;
  end

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div),
    .w_hi   (w_hi),
    .w_lo   (w_lo),
    .b      (w_b),
    .n_hi   (n_hi),
    .n_lo   (n_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      count           <= '0;
      w_hi            <= '0;
      w_lo            <= '0;
      w_b             <= '0;
      is_div          <= 1'b0;
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
      bus.hi          <= '0;
      bus.lo          <= '0;
    end else begin
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
          if (accept) begin
            if (op_is_arith(bus.op)) begin
              if (op_div && bus.b == '0) begin
                // Divide by zero finishes immediately and leaves hi/lo alone.
                state           <= S_DONE;
                bus.done        <= 1'b1;
                bus.div_by_zero <= 1'b1;
              end else begin
                w_hi     <= '0;
                w_lo     <= abs_a;
                w_b      <= abs_b;
                is_div   <= op_div;
                neg_q    <= neg_a ^ neg_b;
                neg_r    <= neg_a;
                count    <= CW'(WIDTH);
                state    <= S_RUN;
                bus.busy <= 1'b1;
              end
            end else if (bus.op == OP_MTHI) begin
              bus.hi <= bus.a;
            end else if (bus.op == OP_MTLO) begin
              bus.lo <= bus.a;
            end
          end
        end
        S_RUN: begin
          if (bus.flush) begin
            state    <= S_IDLE;
            bus.busy <= 1'b0;
          end else begin
            w_hi  <= n_hi;
            w_lo  <= n_lo;
            count <= count - CW'(1);
            if (count == CW'(1)) state <= S_FIX;
          end
        end
        S_FIX: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
          if (!bus.flush) begin
            if (is_div) begin
              bus.hi <= r_fix;
              bus.lo <= q_fix;
            end else begin
              bus.hi <= prod_fix[2*WIDTH-1:WIDTH];
              bus.lo <= prod_fix[WIDTH-1:0];
            end
            bus.done <= 1'b1;
            state    <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed corner cases plus random ops
// compared against an arithmetic model of HI/LO.
module tb_mdu_seq;
  import mdu_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  state_t state;
  int     n_tests = 0;
  int     n_fail  = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mdu_seq_if #(.WIDTH(32)) bus ();

  mdu_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .state (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Runs one op from the idle state and watches up to 44 cycles after issue.
  // flush_at/poke_at/rst_at (0 = never) inject a flush, an MTHI start, or reset
  // during that numbered cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, input int poke_at, input int rst_at);
    logic [31:0] e_hi, e_lo;
    logic        e_dbz;
    int          e_done_cyc, e_busy, busy_cnt, done_cnt, done_cyc;
    longint      sa, sb, p;
    bit          aborted;
    e_hi = m_hi; e_lo = m_lo; e_dbz = 1'b0; e_done_cyc = 0; e_busy = 0;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    case (op)
      OP_MULT:  begin p = sa * sb; {e_hi, e_lo} = p; e_done_cyc = 34; e_busy = 33; end
      OP_MULTU: begin {e_hi, e_lo} = {32'd0, a} * {32'd0, b}; e_done_cyc = 34; e_busy = 33; end
      OP_DIV, OP_DIVU: begin
        if (b == 0) begin
          e_dbz = 1'b1; e_done_cyc = 1;
        end else begin
          e_done_cyc = 34; e_busy = 33;
          if (op == OP_DIV) begin
            p = sa / sb; e_lo = p[31:0];
            p = sa % sb; e_hi = p[31:0];
          end else begin
            e_lo = a / b; e_hi = a % b;
          end
        end
      end
      OP_MTHI: e_hi = a;
      OP_MTLO: e_lo = a;
      default: ;
    endcase
    aborted = (flush_at != 0) || (rst_at != 0);

    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (op == OP_MTHI || op == OP_MTLO) begin
      check("mt_hi", bus.hi, e_hi);
      check("mt_lo", bus.lo, e_lo);
    end
    busy_cnt = 0; done_cnt = 0; done_cyc = 0;
    for (int cyc = 1; cyc <= 44; cyc++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++; done_cyc = cyc;
        check("done_hi", bus.hi, e_hi);
        check("done_lo", bus.lo, e_lo);
        check("done_dbz", bus.div_by_zero, e_dbz);
      end
      if (cyc == flush_at) bus.flush = 1'b1;
      if (cyc == poke_at) begin bus.start = 1'b1; bus.op = OP_MTHI; bus.a = 32'hDEAD; end
      if (cyc == rst_at) rst = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0; bus.start = 1'b0; rst = 1'b0;
      if (cyc == flush_at) check("flush_busy", bus.busy, 1'b0);
      if (cyc == rst_at) begin
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_state", state, S_IDLE);
        m_hi = '0; m_lo = '0;
        break;
      end
    end
    if (aborted) begin
      check("abort_no_done", done_cnt, 0);
    end else begin
      m_hi = e_hi; m_lo = e_lo;
      check("done_count", done_cnt, (e_done_cyc != 0) ? 1 : 0);
      check("done_cycle", done_cyc, e_done_cyc);
      check("busy_cycles", busy_cnt, e_busy);
    end
    check("final_hi", bus.hi, m_hi);
    check("final_lo", bus.lo, m_lo);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    rst = 1'b1; bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_state", state, S_IDLE);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_dbz", bus.div_by_zero, 1'b0);
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);

    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
    check("multu_hi_const", bus.hi, 32'hFFFFFFFE);
    check("multu_lo_const", bus.lo, 32'h00000001);
    run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, 0, 0, 0);
    check("mult_lo_const", bus.lo, 32'hFFFFFFEB);
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 0, 0, 0);
    check("div_lo_const", bus.lo, 32'hFFFFFFFD);
    check("div_hi_const", bus.hi, 32'hFFFFFFFF);
    run_op(OP_MTHI, 32'h11, 32'd0, 0, 0, 0);
    run_op(OP_MTLO, 32'h22, 32'd0, 0, 0, 0);
    run_op(OP_DIVU, 32'd5, 32'd0, 0, 0, 0);
    check("dbz_hi_const", bus.hi, 32'h11);
    run_op(OP_DIVU, 32'd100, 32'd7, 10, 0, 0);
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 5, 0);
    check("ovf_lo_const", bus.lo, 32'h80000000);
    check("ovf_hi_const", bus.hi, 32'd0);
    run_op(OP_MTLO, 32'h5A5A, 32'd0, 0, 0, 0);
    run_op(OP_MULTU, 32'h12345678, 32'h9ABCDEF0, 0, 0, 20);
    run_op(OP_MULTU, 32'd3, 32'd5, 0, 0, 0);
    run_op(3'd6, 32'h1, 32'h2, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h80000000;
      run_op(op, a, b, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
